// File: rtl/shift_exec.sv
// shift_exec: two-stage 32-bit shift execution unit (SLL / SRL / PASS / SRA).
//
// Stage S1 captures the operand, the opcode and a one-hot copy of the shift
// amount. A one-hot barrel shifter sits between S1 and S2, and S2 registers
// the selected result, which drives out_data directly.
//
// Build option: define SHIFT_EXEC_SRA_EN to make op 11 an arithmetic right
// shift. Without it, op 11 is a plain logical right shift and the sign-fill
// path is not built.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds its payload stable while valid is high and ready
// is low. in_ready is combinational from the stage valid bits and out_ready.
// out_valid and out_data come only from registers.

// One-hot 32-bit shifter: amt has exactly one bit set, at position n for a
// shift by n. left = data << n and right = data >> n with zero fill.
module onehot_shift32 (
   input  logic [31:0] data,
   input  logic [31:0] amt,
   output logic [31:0] left,
   output logic [31:0] right
);

   // AND-OR select across the 32 candidate shifts; the one-hot amount picks one
   always_comb begin
      left  = '0;
      right = '0;
      for (int n = 0; n < 32; n++) begin
         if (amt[n]) begin
            left  = left  | (data << n);
            right = right | (data >> n);
         end
      end
   end

endmodule

module shift_exec (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_data,
   input  logic [4:0]  in_shamt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
);

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_PASS = 2'b10;
   localparam logic [1:0] OP_SRA  = 2'b11;

   // Stage S1: decoded request
   logic        s1_valid;
   logic [1:0]  s1_op;
   logic [31:0] s1_data;
   logic [31:0] s1_amt;

   // Stage S2: final result
   logic        s2_valid;
   logic [31:0] s2_data;

   // Stage movement
   logic        s1_load;
   logic        s2_load;

   // Shifter outputs and the selected result
   logic [31:0] sh_left;
   logic [31:0] sh_right;
   logic [31:0] sra_res;
   logic [31:0] result;

   // Binary shift amount to one-hot: bit n set for amount n.
   function automatic logic [31:0] to_onehot(input logic [4:0] a);
      logic [31:0] one;
      one = 32'h0000_0001;
      return one << a;
   endfunction

   // S2 takes S1 whenever it is empty or draining this cycle. S1 refills when
   // it is empty or its contents are moving into S2 on the same edge.
   always_comb begin
      s2_load  = s1_valid && (!s2_valid || out_ready);
      in_ready = !s1_valid || !s2_valid || out_ready;
      s1_load  = in_valid && in_ready;
   end

   onehot_shift32 u_shift (
      .data  (s1_data),
      .amt   (s1_amt),
      .left  (sh_left),
      .right (sh_right)
   );

`ifdef SHIFT_EXEC_SRA_EN
   logic [31:0] sign_mask;

   // Upper n bits to be filled with the sign for a shift by n
   always_comb begin
      sign_mask = '0;
      for (int n = 0; n < 32; n++) begin
         if (s1_amt[n]) begin
            sign_mask = sign_mask | ~(32'hFFFF_FFFF >> n);
         end
      end
      sra_res = sh_right | (s1_data[31] ? sign_mask : 32'h0000_0000);
   end
`else
   // Without the sign-fill option op 11 is a logical right shift
   always_comb begin
      sra_res = sh_right;
   end
`endif

   // Result select by opcode held in S1
   always_comb begin
      result = s1_data;
      case (s1_op)
         OP_SLL:  result = sh_left;
         OP_SRL:  result = sh_right;
         OP_PASS: result = s1_data;
         OP_SRA:  result = sra_res;
         default: result = s1_data;
      endcase
   end

   // S1 registers: valid bit follows load/advance; payload only on load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= 2'b00;
         s1_data  <= 32'h0000_0000;
         s1_amt   <= 32'h0000_0000;
      end else begin
         if (s1_load) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_data  <= in_data;
            s1_amt   <= to_onehot(in_shamt);
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // S2 registers: result held stable until the consumer takes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_data  <= 32'h0000_0000;
      end else begin
         if (s2_load) begin
            s2_valid <= 1'b1;
            s2_data  <= result;
         end else if (out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

   assign out_valid = s2_valid;
   assign out_data  = s2_data;

   // S1 must always carry exactly one amount bit while occupied
   a_s1_onehot: assert property (@(posedge clk) disable iff (rst)
      s1_valid |-> $onehot(s1_amt));

   // A stalled result stays put until it is taken
   a_s2_hold: assert property (@(posedge clk) disable iff (rst)
      (s2_valid && !out_ready) |=> (s2_valid && $stable(s2_data)));

endmodule

// File: doc/shift_exec.md
SHIFT_EXEC -- requirements
Module: shift_exec

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, shift amount fixed at 5 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  request present on in_op/in_data/in_shamt.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 in_op  input  2  operation: 00 SLL, 01 SRL, 10 PASS, 11 SRA.
REQ-007 in_data  input  32  operand.
REQ-008 in_shamt  input  5  shift amount, 0..31, binary.
REQ-009 out_valid  output  1  result present on out_data.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 out_data  output  32  shift result.

Function
REQ-012 Two-stage pipeline SHALL be used: S1 (decode) registers in_data, in_op, and the one-hot form of in_shamt (bit n set for amount n, exactly one bit set); S2 (result) registers the final result.
REQ-013 Between S1 and S2 the team's one-hot 32-bit shifter SHALL be instantiated, driven by the S1 one-hot amount and S1 operand; its left/right outputs feed S2 result select.
REQ-014 Result select SHALL be: SLL -> left output; SRL -> right output; PASS -> S1 operand unchanged; SRA -> per REQ-024/REQ-025.
REQ-015 Each stage SHALL hold a valid bit; a transfer occurs on a cycle where the valid bit is high and the downstream stage or port is ready.
REQ-016 S2 SHALL load when S1 valid and (S2 empty or out_ready); S1 SHALL load when in_valid and (S1 empty or S1 advancing into S2).
REQ-017 in_ready SHALL equal (S1 empty) or (S2 empty) or out_ready, combinationally; no combinational path from in_* data to out_*.
REQ-018 Latency SHALL be exactly 2 cycles from acceptance to out_valid with out_ready held high; throughput one result per cycle.
REQ-019 Under out_ready low, out_valid and out_data SHALL stay stable until transfer; up to two requests may be buffered, then in_ready SHALL drop.
REQ-020 Simultaneous S2 drain and S1 refill in one cycle SHALL lose no data and duplicate no data.
REQ-021 Shift amount 0 SHALL return the operand unchanged for SLL, SRL and SRA; amount 31 SHALL yield bit 0 moved to bit 31 (SLL) or bit 31 moved to bit 0 (SRL).
REQ-022 Results SHALL be delivered in acceptance order.

Reset
REQ-023 While rst high: out_valid=0, both stage valid bits=0, out_data=32'h0, S1 registers=0; in_ready SHALL read 1 once rst deasserts; in-flight requests at reset assertion SHALL be discarded, never emitted.

Configuration
REQ-024 Macro SHIFT_EXEC_SRA_EN defined: op 11 SHALL produce the arithmetic right shift, vacated upper n bits filled with S1 operand bit 31.
REQ-025 Macro SHIFT_EXEC_SRA_EN undefined: op 11 SHALL behave identically to SRL (zero fill); no sign-fill logic present.

Verification
REQ-026 Reset mid-stream: two requests accepted, rst pulsed before output -> out_valid=0 after reset, no result ever emitted for those requests.
REQ-027 Basic ops, out_ready=1: in_data=32'h8000_00F1, shamt=4; SLL -> 32'h0000_0F10, SRL -> 32'h0800_000F, PASS -> 32'h8000_00F1, each at exactly 2 cycles after acceptance.
REQ-028 SRA: in_data=32'h8000_0000, shamt=31 -> 32'hFFFF_FFFF with SHIFT_EXEC_SRA_EN, 32'h0000_0001 without; shamt=0 -> 32'h8000_0000 both builds.
REQ-029 Backpressure: stream 5 SLL requests (data=1, shamt=0..4), out_ready low for cycles 3-6 -> in_ready low once two held, out_data stable while stalled, outputs 1,2,4,8,16 in order, none lost.
REQ-030 Full throughput: 32 back-to-back SRL requests data=32'hFFFF_FFFF, shamt=0..31, out_ready=1 -> 32 consecutive out_valid cycles, result k = 32'hFFFF_FFFF >> k.
REQ-031 Random: 10k random op/data/shamt with random in_valid/out_ready -> every output matches reference model, order preserved, out_valid never asserted without a prior acceptance.
